prio_scan: RTL and testbench
============================

# prio_scan

Sequential successor to the combinational MSB priority encoder: accepts a WIDTH-bit word over a valid/ready handshake, then emits the index of every set bit, one per beat, in priority order (MSB-first or LSB-first by parameter). It sits between candidate/sieve bitmaps and downstream index consumers in the prime generator datapath, replacing ad-hoc "encode, clear, re-encode" loops.

## Interface
- WIDTH, 16: input word width; 2..256.
- LSB_FIRST, 0: 0 emits indices high-to-low; 1 emits them low-to-high.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  WIDTH  word to scan.
- out_valid  out  1  out_idx, out_last, out_zero valid.
- out_ready  in  1  consumer takes the beat.
- out_idx  out  8  bit index of current beat, zero-extended.
- out_last  out  1  current beat is the word's final beat.
- out_zero  out  1  accepted word was all-zero; out_idx=0 on this beat.
- out_cnt  out  8  ordinal of current beat within the word, from 0 (PRIO_SCAN_CNT_EN only).

## Operation
- States: IDLE, SCAN. Reset forces IDLE, word register 0, out_valid=0, out_last=0, out_zero=0, out_idx=0, out_cnt=0.
- IDLE: in_ready=1, out_valid=0. On in_valid&in_ready: latch in_data into word register, set zero flag = ~|in_data, clear out_cnt, go SCAN.
- SCAN: out_valid=1. out_idx = highest set bit of word register (LSB_FIRST=0) or lowest (LSB_FIRST=1), found by log2(WIDTH)-step halving search. out_last=1 when exactly one bit remains set, or when the zero flag is set.
- Fire (out_valid&out_ready): clear bit out_idx in word register, increment out_cnt. If out_last: return to IDLE unless a new word is accepted in the same cycle.
- in_ready = IDLE | (fire & out_last). A same-cycle accept loads the new word and stays in SCAN. No bubble between words.
- All-zero word produces exactly one beat: out_zero=1, out_idx=0, out_last=1.
- Backpressure: while out_valid & ~out_ready, out_idx/out_last/out_zero/out_cnt and the word register hold.
- in_data is ignored when in_ready=0.
- Reset asserted mid-scan discards the word. Outputs take their reset values at the next edge. No partial beats follow.

## Timing
- Accept at edge N -> first beat valid after edge N, i.e. during cycle N+1. Latency is 1 cycle.
- Throughput is one beat per cycle with out_ready=1. A word with k set bits occupies k cycles in SCAN (1 cycle if k=0).
- out_idx is combinational from the word register through the search tree. No output depends combinationally on in_* or out_ready, except in_ready, which depends on out_ready.

## Configuration
- PRIO_SCAN_CNT_EN defined: out_cnt port and 8-bit beat counter exist. Counter clears on accept and increments on fire. With WIDTH=256 it saturates at 255.
- PRIO_SCAN_CNT_EN undefined: no out_cnt port and no counter. All other behaviour is identical.

## Structure
- Package prio_pkg holds the state enum (IDLE, SCAN) and IDX_W=8 for all index ports.
- One sub-module, prio_find: combinational halving-search encoder with parameters WIDTH and LSB_FIRST, input word, output 8-bit index. It is the same algorithm as the combinational MSB encoder, extended with the LSB mode.
- prio_scan contains the FSM, word register, zero flag, optional counter and the handshake logic.

## Test plan
- WIDTH=16, LSB_FIRST=0, out_ready=1, in_data=16'h8421 -> beats idx 15,10,5,0 on consecutive cycles. out_last only on idx 0. in_ready=0 during the first three beats.
- LSB_FIRST=1, in_data=16'h8421 -> beats idx 0,5,10,15. out_last on 15. With PRIO_SCAN_CNT_EN: out_cnt 0,1,2,3.
- in_data=16'h0000 -> single beat with out_zero=1, out_idx=0, out_last=1. Back to IDLE next cycle.
- in_data=16'h0003, out_ready low for 3 cycles after first beat -> idx 1 held stable for 4 cycles, then idx 0 with out_last=1.
- Word A=16'h0010 followed immediately by B=16'h0101 -> B is accepted in the cycle A's last beat fires. The next cycle shows idx 8, then idx 0. No idle cycle between words.
- rst_n low for one cycle during the second beat of 16'hF000 -> out_valid=0 and in_ready=1 the cycle after reset. No further beats until a new word arrives.

Source files
------------

// File: rtl/prio_pkg.sv
// prio_pkg: shared types and constants for the prio_scan block.
//   state_t : scanner FSM states (IDLE, SCAN)
//   IDX_W   : width of every bit-index port (8 bits covers WIDTH up to 256)
package prio_pkg;

    localparam int IDX_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/prio_find.sv
// prio_find: combinational priority encoder using a log2(WIDTH)-step
// halving search. It returns the index of the highest set bit when
// LSB_FIRST=0, or of the lowest set bit when LSB_FIRST=1. An all-zero word
// gives index 0.
// Ports:
//   word : input word, WIDTH bits
//   idx  : selected bit index, IDX_W bits, zero-extended
module prio_find
    import prio_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int LSB_FIRST = 0
) (
    input  logic [WIDTH-1:0] word,
    output logic [IDX_W-1:0] idx
);

    // The word is padded up to a power of two so that every halving step
    // splits its window into two equal halves.
    localparam int STEPS = $clog2(WIDTH);
    localparam int P     = 1 << STEPS;

    logic [P-1:0]     padded;
    logic [P-1:0]     mask;
    logic [IDX_W-1:0] base;

    always_comb begin
        padded = '0;
        padded[WIDTH-1:0] = word;
        base = '0;
        mask = '0;
        for (int s = STEPS - 1; s >= 0; s--) begin
            // mask covers the lower half of the current window: 2^s bits at base
            mask = ({P{1'b1}} >> (P - (1 << s))) << base;
            if (LSB_FIRST != 0) begin
                // Move to the upper half only when the lower half is empty.
                if (~|(padded & mask)) base = base + IDX_W'(1 << s);
            end else begin
                // Move to the upper half whenever it holds any set bit.
                mask = mask << (1 << s);
                if (|(padded & mask)) base = base + IDX_W'(1 << s);
            end
        end
        // In LSB mode an empty word would walk base to the top; force 0.
        idx = (|word) ? base : '0;
    end

endmodule

// File: rtl/prio_scan.sv
// prio_scan: accepts a WIDTH-bit word and emits the index of each set bit,
// one beat per cycle, MSB-first (LSB_FIRST=0) or LSB-first (LSB_FIRST=1).
// An all-zero word produces one beat with out_zero=1, out_idx=0, out_last=1.
// Optional feature macro: PRIO_SCAN_CNT_EN adds the out_cnt beat ordinal.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input word handshake, in_data is the word
//   out_valid/out_ready : output beat handshake
//   out_idx             : bit index of the current beat
//   out_last            : current beat is the last beat of the word
//   out_zero            : the word was all-zero
//   out_cnt             : beat ordinal within the word (PRIO_SCAN_CNT_EN)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload steady until that
// edge. out_valid and its payload come only from registers. in_ready is
// the only output that depends combinationally on an input, and that
// input is out_ready.
module prio_scan
    import prio_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
`ifdef PRIO_SCAN_CNT_EN
    output logic [IDX_W-1:0] out_cnt,
`endif
    output logic             out_zero
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] word_r;
    logic             zero_r;
    logic             fire;
    logic             accept;
    logic             one_left;

    prio_find #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_find (
        .word (word_r),
        .idx  (out_idx)
    );

    // x & (x-1) clears the lowest set bit; if nothing remains, at most one
    // bit was set.
    assign one_left  = ~|(word_r & (word_r - WIDTH'(1)));
    assign out_valid = (state == SCAN);
    assign out_last  = out_valid & (zero_r | one_left);
    assign out_zero  = out_valid & zero_r;
    assign fire      = out_valid & out_ready;
    // Taking a new word as the last beat fires leaves no idle cycle between words.
    assign in_ready  = (state == IDLE) | (fire & out_last);
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SCAN;
            SCAN: if (fire && out_last) state_nxt = accept ? SCAN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            word_r <= '0;
            zero_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                word_r <= in_data;
                zero_r <= ~|in_data;
            end else if (fire) begin
                word_r <= word_r & ~(WIDTH'(1) << out_idx);
            end
        end
    end

`ifdef PRIO_SCAN_CNT_EN
    // Saturates at 255, which a 256-bit word with every bit set reaches on its last beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else if (accept) begin
            out_cnt <= '0;
        end else if (fire && out_cnt != {IDX_W{1'b1}}) begin
            out_cnt <= out_cnt + IDX_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_prio_scan.sv
// tb_prio_scan: drives one MSB-first and one LSB-first prio_scan from the
// same inputs. The set-bit count of a word does not depend on scan order,
// so both instances stay in lockstep. Expected beats come from a
// list-of-set-bits model held in queues.
module tb_prio_scan;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_ready;

    logic       in_ready_m, out_valid_m, out_last_m, out_zero_m;
    logic [7:0] out_idx_m;
    logic       in_ready_l, out_valid_l, out_last_l, out_zero_l;
    logic [7:0] out_idx_l;
`ifdef PRIO_SCAN_CNT_EN
    logic [7:0] out_cnt_m, out_cnt_l;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Each entry packs one beat as {zero, last, cnt[7:0], idx[7:0]}.
    logic [17:0] exp_q_msb[$];
    logic [17:0] exp_q_lsb[$];

    prio_scan #(.WIDTH(WIDTH), .LSB_FIRST(0)) dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_m),
        .in_data   (in_data),
        .out_valid (out_valid_m),
        .out_ready (out_ready),
        .out_idx   (out_idx_m),
        .out_last  (out_last_m),
`ifdef PRIO_SCAN_CNT_EN
        .out_cnt   (out_cnt_m),
`endif
        .out_zero  (out_zero_m)
    );

    prio_scan #(.WIDTH(WIDTH), .LSB_FIRST(1)) dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_l),
        .in_data   (in_data),
        .out_valid (out_valid_l),
        .out_ready (out_ready),
        .out_idx   (out_idx_l),
        .out_last  (out_last_l),
`ifdef PRIO_SCAN_CNT_EN
        .out_cnt   (out_cnt_l),
`endif
        .out_zero  (out_zero_l)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: list every set bit, then emit them in each order.
    task automatic push_word(input logic [WIDTH-1:0] w);
        int bits[$];
        int k;
        for (int i = 0; i < WIDTH; i++)
            if (w[i]) bits.push_back(i);
        k = bits.size();
        if (k == 0) begin
            exp_q_msb.push_back({1'b1, 1'b1, 8'd0, 8'd0});
            exp_q_lsb.push_back({1'b1, 1'b1, 8'd0, 8'd0});
        end else begin
            for (int j = 0; j < k; j++) begin
                exp_q_msb.push_back({1'b0, (j == k - 1), 8'(j), 8'(bits[k - 1 - j])});
                exp_q_lsb.push_back({1'b0, (j == k - 1), 8'(j), 8'(bits[j])});
            end
        end
    endtask

    task automatic check_beat(input string name, input logic [17:0] e,
                              input logic [7:0] idx, input logic last,
                              input logic zero, input logic [7:0] cnt);
        check({name, ".idx"}, 32'(idx), 32'(e[7:0]));
        check({name, ".last"}, 32'(last), 32'(e[16]));
        check({name, ".zero"}, 32'(zero), 32'(e[17]));
`ifdef PRIO_SCAN_CNT_EN
        check({name, ".cnt"}, 32'(cnt), 32'(e[15:8]));
`else
        if (cnt !== 8'd0) check({name, ".cnt"}, 32'(cnt), 32'd0);
`endif
    endtask

    // Driver: called just after a falling edge. Applies inputs, checks
    // outputs away from the rising edge, then advances the model.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r);
        logic model_rdy;
        logic busy;
        logic [7:0] cm, cl;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        busy = (exp_q_msb.size() != 0);
        model_rdy = !busy || (r && exp_q_msb.size() == 1);
`ifdef PRIO_SCAN_CNT_EN
        cm = out_cnt_m;
        cl = out_cnt_l;
`else
        cm = 8'd0;
        cl = 8'd0;
`endif
        check("msb.in_ready", 32'(in_ready_m), 32'(model_rdy));
        check("lsb.in_ready", 32'(in_ready_l), 32'(model_rdy));
        check("msb.out_valid", 32'(out_valid_m), 32'(busy));
        check("lsb.out_valid", 32'(out_valid_l), 32'(busy));
        if (busy) begin
            check_beat("msb", exp_q_msb[0], out_idx_m, out_last_m, out_zero_m, cm);
            check_beat("lsb", exp_q_lsb[0], out_idx_l, out_last_l, out_zero_l, cl);
        end
        @(posedge clk);
        if (busy && r) begin
            void'(exp_q_msb.pop_front());
            void'(exp_q_lsb.pop_front());
        end
        if (v && model_rdy) push_word(d);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        exp_q_msb.delete();
        exp_q_lsb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.out_valid", 32'(out_valid_m | out_valid_l), 32'd0);
        check("rst.in_ready", 32'({in_ready_m, in_ready_l}), 32'd3);
        check("rst.out_idx", 32'({out_idx_m, out_idx_l}), 32'd0);
        check("rst.out_last", 32'(out_last_m | out_last_l), 32'd0);
        check("rst.out_zero", 32'(out_zero_m | out_zero_l), 32'd0);
`ifdef PRIO_SCAN_CNT_EN
        check("rst.out_cnt", 32'({out_cnt_m, out_cnt_l}), 32'd0);
`endif
        @(negedge clk);
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return WIDTH'(1) << $urandom_range(0, WIDTH - 1);
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Four bits, both orders, full throughput.
        cycle(1'b1, 16'h8421, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0000, 1'b1);

        // All-zero word: one beat, then idle.
        cycle(1'b1, 16'h0000, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 16'h0000, 1'b1);

        // Backpressure holds the first beat.
        cycle(1'b1, 16'h0003, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b1);

        // Back-to-back words with no bubble between them.
        cycle(1'b1, 16'h0010, 1'b1);
        cycle(1'b1, 16'h0101, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b1);

        // Reset during the second beat discards the word.
        cycle(1'b1, 16'hF000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b1);

        // Random traffic with random backpressure; in_data varies even when not ready.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), rand_word(), ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 40; i++) cycle(1'b0, 16'h0000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
